ram64: RTL

- 64-word x 16-bit random-access memory for the Hack data path.
- Sits directly downstream of the 16-bit load-enabled register: each word is one such register with an added asynchronous clear.
- Banked as 8 x 8 words with a two-level address decode and a two-level read mux.
- Building block for the larger RAM (RAM512 upward) and the data-memory map.

---
 rtl/ram64.sv | 103 ++++++++++
 1 files changed

// File: rtl/ram64.sv
// ram64: 2**ADDR_BITS words x WIDTH bits random-access memory for the Hack
// data path. Each word is a load-enabled register with an asynchronous clear.
// The words are grouped into banks: the upper half of the address picks a bank
// and the lower half picks a word inside that bank. Reads are combinational.
//
// Ports:
//   clock    - system clock; writes occur on its rising edge
//   reset_n  - asynchronous active-low clear of every word
//   in       - write data
//   address  - word select for both read and write
//   load     - write enable, sampled on the rising clock edge
//   out      - contents of word[address], no output register
//
// ADDR_BITS must be even and at least 2.
module ram64 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  output logic [WIDTH-1:0]     out
);

  localparam int unsigned SEL_BITS   = ADDR_BITS / 2;
  localparam int unsigned BANKS      = 2 ** SEL_BITS;
  localparam int unsigned BANK_WORDS = 2 ** SEL_BITS;
  localparam int unsigned DEPTH      = BANKS * BANK_WORDS;

  // Address split: upper half selects the bank, lower half the word.
  logic [SEL_BITS-1:0] bank_idx;
  logic [SEL_BITS-1:0] word_idx;

  // First-level decode: one-hot bank and word selects.
  logic [BANKS-1:0]      bank_sel;
  logic [BANK_WORDS-1:0] word_sel;

  // Second-level decode: one-hot per-word write enables.
  logic [DEPTH-1:0] word_en;

  // Storage.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Read mux: first level picks the addressed word in every bank,
  // second level picks the addressed bank.
  logic [WIDTH-1:0] bank_rd [BANKS];

  always_comb begin
    bank_idx = address[ADDR_BITS-1:SEL_BITS];
    word_idx = address[SEL_BITS-1:0];
  end

  always_comb begin
    bank_sel = '0;
    word_sel = '0;
    bank_sel[bank_idx] = 1'b1;
    word_sel[word_idx] = 1'b1;
  end

  // At most one enable is asserted since both selects are one-hot.
  always_comb begin
    word_en = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      for (int unsigned w = 0; w < BANK_WORDS; w++) begin
        word_en[b * BANK_WORDS + w] = load & bank_sel[b] & word_sel[w];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = word_en[i] ? in : mem_q[i];
    end
  end

  // Asynchronous clear dominates any concurrent write edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < BANKS; b++) begin
      bank_rd[b] = mem_q[b * BANK_WORDS + int'(word_idx)];
    end
  end

  // Storage is cleared while reset_n is low, so out reads 0 then as well.
  always_comb begin
    out = bank_rd[bank_idx];
  end

endmodule
